avalon_mem_responder: RTL and testbench
=======================================

Name: avalon_mem_responder

Overview:
- Avalon memory-mapped slave (responder) answering the CPU's bus master: single-port word RAM with programmable wait states, byte-enabled writes and registered read data.
- Sits between mips_cpu_bus and the testbench. It is the standard memory model for CPU simulation and is synthesisable for FPGA bring-up.
- Byte lanes are stored as presented on the bus (little-endian lanes). Endianness conversion stays in the CPU.

Parameters:
- BASE_ADDR, 32'hBFC0_0000, byte address mapped to word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 4.
- WAIT_CYCLES, 2, waitrequest-high cycles inserted before each transfer is accepted; 0 means zero-wait.
- LFSR_SEED, 16'hACE1, nonzero seed, used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  32  byte address from master; bits [1:0] ignored.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  lane enables; bit i qualifies writedata[8i+7:8i].
- waitrequest  out  1  stall; a transfer is accepted in a cycle with a request high and waitrequest low.
- readdata  out  32  registered read data.
- protocol_error  out  1  sticky violation flag.

Behaviour:
- Reset (synchronous, active-high):
  - readdata=0, protocol_error=0, state=IDLE, wait counter=0.
  - RAM contents are NOT cleared.
  - Reset asserted mid-wait aborts the pending transfer with no memory effect.
- Address decode:
  - offset=address-BASE_ADDR (32-bit wrap arithmetic); word index=offset[31:2].
  - In range when offset[31:2] < DEPTH_WORDS.
  - Out of range: reads return 32'h0000_0000, writes are discarded. Neither sets protocol_error.
- States:
  - IDLE:
    - Request with WAIT_CYCLES=0: waitrequest=0 combinationally and the transfer is accepted this cycle; stay IDLE.
    - Request with WAIT_CYCLES>0: waitrequest=1; latch address/read/write; counter=WAIT_CYCLES-1; go to WAIT.
    - No request: waitrequest=0.
  - WAIT:
    - Counter>0: waitrequest=1, decrement.
    - Counter=0: go to ACCEPT.
  - ACCEPT:
    - waitrequest=0 and the transfer is accepted; go to IDLE.
  - Total stall is exactly WAIT_CYCLES cycles per transfer.
- waitrequest is combinational from state and request. It is 0 whenever read=write=0 in IDLE.
- Accepted read:
  - readdata <= mem[index] on the accepting edge.
  - Valid from the next cycle; held stable until the next accepted read.
  - Writes never change readdata.
- Accepted write:
  - For each i with byteenable[i]=1, mem[index] lane i <= writedata lane i. Other lanes are unchanged.
  - byteenable=0 is a legal no-op.
- Back-to-back transfers:
  - A request held high after acceptance is a new transfer and incurs the full WAIT_CYCLES again.
  - Read-after-write to the same word returns the new data.
- Protocol violations (each sets protocol_error until reset):
  - read and write both high: the write proceeds, the read is ignored, readdata is unchanged.
  - Request dropped while in WAIT/ACCEPT: return to IDLE with no memory effect.
  - address/read/write changed while in WAIT/ACCEPT versus the latched values: the latched values are used.

Optional Feature:
- Macro: AVALON_MEM_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to LFSR_SEED, advances one step per accepted transfer.
  - The wait count for each transfer is lfsr[7:0] mod (WAIT_CYCLES+1), giving 0..WAIT_CYCLES.
  - A count of 0 behaves as the zero-wait IDLE path.
- Undefined: every transfer waits exactly WAIT_CYCLES cycles, and no LFSR logic is present.

Decomposition:
- Package avalon_mem_pkg:
  - mem_state_t enum {MEM_IDLE, MEM_WAIT, MEM_ACCEPT}.
  - Constant RESET_VECTOR = 32'hBFC0_0000.
  - Constant LFSR_TAPS.
- Sub-module wait_state_gen:
  - Owns the counter and, under the macro, the LFSR.
  - Inputs: start, accept. Outputs: wait count and done.
- RAM array, decode and readdata register stay in the top module.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to 32'hBFC0_0000 with be=4'b1111, WAIT_CYCLES=2, then read it back:
  - waitrequest is high for exactly 2 cycles per transfer.
  - readdata=32'hDEAD_BEEF the cycle after the read is accepted.
- Partial write: preload 32'h1122_3344, then write 32'hAABB_CCDD with be=4'b0101 → read returns 32'h11BB_33DD.
- WAIT_CYCLES=0, back-to-back reads of words 0 and 1 (holding 32'h0000_0001 and 32'h0000_0002) → waitrequest never high; readdata is 1 then 2 on consecutive cycles.
- Read 32'h0000_0000 (out of range) → readdata=0, protocol_error stays 0. A write there leaves the RAM unchanged.
- Assert read and write together → write commits, readdata is unchanged, protocol_error=1.
- Reset mid-WAIT → waitrequest goes low, protocol_error clears, memory is unchanged.
- With AVALON_MEM_RANDOM_WAIT_EN and seed 16'hACE1, run 100 reads → every stall is within 0..2 cycles, and at least two distinct stall lengths occur.

Source files
------------

// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon memory responder.
package avalon_mem_pkg;
  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ACCEPT} mem_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bus between the CPU master and the memory responder.
interface avalon_mem_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        protocol_error;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, protocol_error
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, protocol_error
  );
endinterface

// File: rtl/wait_state_gen.sv
// Wait-state counter for the memory responder; AVALON_MEM_RANDOM_WAIT_EN
// replaces the fixed wait length with an LFSR-driven one.
module wait_state_gen
  import avalon_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          CNT_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accept,
  output logic [CNT_W-1:0] wait_len,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

`ifdef AVALON_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // lfsr only moves on acceptance, so the length is stable for a whole transfer
  assign wait_len = CNT_W'(32'(lfsr[7:0]) % (WAIT_CYCLES + 1));
`else
  logic [15:0] seed_unused;
  assign seed_unused = LFSR_SEED;
  assign wait_len    = CNT_W'(WAIT_CYCLES);
`endif

  // The IDLE cycle is the first stall, so WAIT holds for the remaining wait_len-1
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (start) cnt <= wait_len - CNT_W'(1);
    else if (accept) cnt <= '0;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt <= CNT_W'(1));
endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM word RAM responder with wait states, byte enables and registered
// read data. Optional random wait lengths: AVALON_MEM_RANDOM_WAIT_EN.
module avalon_mem_responder
  import avalon_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                    clk,
  input logic                    reset,
  avalon_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  mem_state_t       state, state_nxt;
  logic             req, start, accept, stall, done, violation;
  logic [CNT_W-1:0] wait_len;
  logic [31:0]      lat_addr, eff_addr, offset;
  logic             lat_read, lat_write, eff_read, eff_write;
  logic             in_range, offset_unused;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      readdata_q;
  logic             error_q;

  assign req = bus.read | bus.write;

  wait_state_gen #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .LFSR_SEED   (LFSR_SEED),
    .CNT_W       (CNT_W)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .accept   (accept),
    .wait_len (wait_len),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= MEM_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE:   if (req && wait_len != '0)
                    state_nxt = (wait_len == CNT_W'(1)) ? MEM_ACCEPT : MEM_WAIT;
      MEM_WAIT:   if (!req) state_nxt = MEM_IDLE;
                  else if (done) state_nxt = MEM_ACCEPT;
      MEM_ACCEPT: state_nxt = MEM_IDLE;
      default:    state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    start  = 1'b0;
    accept = 1'b0;
    case (state)
      MEM_IDLE: if (req) begin
        if (wait_len == '0) accept = 1'b1;
        else begin
          stall = 1'b1;
          start = 1'b1;
        end
      end
      MEM_WAIT:   stall  = 1'b1;
      MEM_ACCEPT: accept = req;
      default:    stall  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      lat_addr  <= bus.address;
      lat_read  <= bus.read;
      lat_write <= bus.write;
    end
  end

  // Once a transfer is pending, the latched request is authoritative
  always_comb begin
    eff_addr  = bus.address;
    eff_read  = bus.read;
    eff_write = bus.write;
    if (state != MEM_IDLE) begin
      eff_addr  = lat_addr;
      eff_read  = lat_read;
      eff_write = lat_write;
    end
  end

  assign offset        = eff_addr - BASE_ADDR;
  assign offset_unused = ^offset[1:0];
  assign in_range      = offset[31:2] < 30'(DEPTH_WORDS);
  assign idx           = offset[IDX_W+1:2];

  assign violation = (bus.read & bus.write)
                   | ((state != MEM_IDLE) &
                      (!req || bus.address != lat_addr ||
                       bus.read != lat_read || bus.write != lat_write));

  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else if (violation) error_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && eff_write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  // A simultaneous write wins, so the read side must not disturb readdata
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else if (accept && eff_read && !eff_write)
      readdata_q <= in_range ? mem[idx] : 32'h0000_0000;
  end

  assign bus.waitrequest    = stall;
  assign bus.readdata       = readdata_q;
  assign bus.protocol_error = error_q;
endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed and randomized bench for avalon_mem_responder against a word-array model.
module tb_avalon_mem_responder;
  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avalon_mem_responder_if a_if ();
  avalon_mem_responder_if z_if ();

  avalon_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .LFSR_SEED(16'hACE1)
  ) u_a (.clk(clk), .reset(reset), .bus(a_if));

  avalon_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .LFSR_SEED(16'hACE1)
  ) u_z (.clk(clk), .reset(reset), .bus(z_if));

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_stall(input int stall);
`ifdef AVALON_MEM_RANDOM_WAIT_EN
    chk("stall_range", 32'(stall <= 2), 32'd1);
`else
    chk("stall", 32'(stall), 32'd2);
`endif
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic int model_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (model_hit(a)) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[model_word(a)][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  // Issues one transfer on the WAIT_CYCLES=2 instance; returns at accept edge + 1
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, output int stall);
    a_if.read = rd; a_if.write = wr; a_if.address = a;
    a_if.writedata = wd; a_if.byteenable = be;
    stall = 0;
    @(negedge clk);
    while (a_if.waitrequest && stall < 64) begin
      stall++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_if.read = 1'b0; a_if.write = 1'b0;
    if (wr) model_write(a, wd, be);
    else if (rd) exp_rd = model_hit(a) ? mdl[model_word(a)] : 32'h0;
    chk_stall(stall);
    chk("readdata", a_if.readdata, exp_rd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int st;
    logic [31:0] a, d;
    logic rd;
    logic [2:0] seen;
    int nseen;

    reset = 1'b1;
    a_if.read = 0; a_if.write = 0; a_if.address = 0; a_if.writedata = 0; a_if.byteenable = 0;
    z_if.read = 0; z_if.write = 0; z_if.address = 0; z_if.writedata = 0; z_if.byteenable = 0;
    exp_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_readdata", a_if.readdata, 32'h0);
    chk("reset_error", 32'(a_if.protocol_error), 32'h0);
    chk("idle_waitrequest", 32'(a_if.waitrequest), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, st);

    xfer(1'b0, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, st);
    xfer(1'b1, 1'b0, BASE, 32'h0, 4'h0, st);
    chk("deadbeef", a_if.readdata, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, BASE + 4, 32'h1122_3344, 4'hF, st);
    xfer(1'b0, 1'b1, BASE + 4, 32'hAABB_CCDD, 4'b0101, st);
    xfer(1'b0, 1'b1, BASE + 4, 32'hFFFF_FFFF, 4'b0000, st);
    xfer(1'b1, 1'b0, BASE + 4, 32'h0, 4'h0, st);
    chk("partial", a_if.readdata, 32'h11BB_33DD);

    xfer(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, st);
    chk("oob_read", a_if.readdata, 32'h0);
    xfer(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, st);
    xfer(1'b0, 1'b1, BASE + 32'(DEPTH * 4), 32'h8765_4321, 4'hF, st);
    xfer(1'b1, 1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'h0, st);
    xfer(1'b1, 1'b0, BASE, 32'h0, 4'h0, st);
    chk("oob_error", 32'(a_if.protocol_error), 32'h0);
    xfer(1'b0, 1'b1, BASE + 32'((DEPTH - 1) * 4), 32'hCAFE_F00D, 4'hF, st);
    xfer(1'b1, 1'b0, BASE + 32'((DEPTH - 1) * 4) + 3, 32'h0, 4'h0, st);

    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      xfer(rd, !rd, a, d, 4'($urandom_range(0, 15)), st);
    end
    chk("random_error", 32'(a_if.protocol_error), 32'h0);

    xfer(1'b1, 1'b0, BASE + 8, 32'h0, 4'h0, st);
    xfer(1'b1, 1'b1, BASE + 12, 32'h5A5A_5A5A, 4'hF, st);
    chk("rdwr_error", 32'(a_if.protocol_error), 32'h1);
    xfer(1'b1, 1'b0, BASE + 12, 32'h0, 4'h0, st);
    chk("rdwr_commit", a_if.readdata, 32'h5A5A_5A5A);
    chk("error_sticky", 32'(a_if.protocol_error), 32'h1);

`ifndef AVALON_MEM_RANDOM_WAIT_EN
    xfer(1'b0, 1'b1, BASE + 16, 32'h4444_4444, 4'hF, st);
    a_if.write = 1'b1; a_if.address = BASE + 16;
    a_if.writedata = 32'hFFFF_FFFF; a_if.byteenable = 4'hF;
    @(posedge clk); #1;
    chk("mid_wait_stall", 32'(a_if.waitrequest), 32'h1);
    reset = 1'b1; a_if.write = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_rd = 32'h0;
    @(negedge clk);
    chk("abort_waitrequest", 32'(a_if.waitrequest), 32'h0);
    chk("abort_error", 32'(a_if.protocol_error), 32'h0);
    chk("abort_readdata", a_if.readdata, 32'h0);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, BASE + 16, 32'h0, 4'h0, st);
    chk("abort_mem", a_if.readdata, 32'h4444_4444);
`endif

    z_if.write = 1'b1; z_if.address = BASE; z_if.writedata = 32'h1; z_if.byteenable = 4'hF;
    @(negedge clk); chk("z_wr0_wait", 32'(z_if.waitrequest), 32'h0);
    @(posedge clk); #1;
    z_if.address = BASE + 4; z_if.writedata = 32'h2;
    @(negedge clk); chk("z_wr1_wait", 32'(z_if.waitrequest), 32'h0);
    @(posedge clk); #1;
    z_if.write = 1'b0; z_if.read = 1'b1; z_if.address = BASE;
    @(negedge clk); chk("z_rd0_wait", 32'(z_if.waitrequest), 32'h0);
    @(posedge clk); #1;
    chk("z_rd0", z_if.readdata, 32'h1);
    z_if.address = BASE + 4;
    @(negedge clk); chk("z_rd1_wait", 32'(z_if.waitrequest), 32'h0);
    @(posedge clk); #1;
    chk("z_rd1", z_if.readdata, 32'h2);
    z_if.read = 1'b0;
    chk("z_error", 32'(z_if.protocol_error), 32'h0);

`ifdef AVALON_MEM_RANDOM_WAIT_EN
    seen = 3'b000;
    for (int n = 0; n < 100; n++) begin
      xfer(1'b1, 1'b0, BASE + 32'($urandom_range(0, DEPTH - 1) * 4), 32'h0, 4'h0, st);
      if (st <= 2) seen[st] = 1'b1;
    end
    nseen = 0;
    for (int i = 0; i < 3; i++) nseen += int'(seen[i]);
    chk("distinct_stalls", 32'(nseen >= 2), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
